hilo_muldiv_unit: RTL and testbench
===================================

# hilo_muldiv_unit

Iterative, parametrised multiply/divide unit owning the HI/LO register pair. It replaces the single-cycle HI/LO path in the EX stage of the pipelined MIPS datapath. MULT/MULTU/DIV/DIVU/MADD/MSUB run over multiple cycles. The unit raises a stall to the hazard logic whenever a new HI/LO operation or an MFHI/MFLO read collides with a busy unit.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and ≥ 4

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- start  in  1  EX-stage instruction is a HI/LO op (valid this cycle)
- op  in  3  operation code, hilo_pkg encoding
- a  in  WIDTH  rs operand (dividend / multiplicand)
- b  in  WIDTH  rt operand (divisor / multiplier)
- kill  in  1  flush of the EX-stage instruction; aborts any in-flight op
- mf_req  in  1  ID/EX instruction reads HI or LO (MFHI/MFLO)
- stall  out  1  freeze PC, IF/ID and ID/EX this cycle
- busy  out  1  RUN or FIX state
- done  out  1  one-cycle pulse: HI/LO just committed by a multi-cycle op
- hi_out  out  WIDTH  architectural HI
- lo_out  out  WIDTH  architectural LO

## Operation
- Op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MSUB=5, MTHI=6, MTLO=7.
- States: IDLE, RUN, FIX.
  - IDLE→RUN when start & ~kill & op∈{0..5}.
  - RUN counts WIDTH iterations, then →FIX.
  - FIX→IDLE unconditionally, after committing HI/LO.
- MTHI/MTLO in IDLE: write a to HI/LO at the same edge. The unit stays in IDLE and done does not pulse.
- Signed ops (MULT, DIV, MADD, MSUB):
  - The core works on magnitudes.
  - FIX applies the sign: product sign = a^b; quotient sign = a^b; remainder takes the dividend's sign.
- Multiply: radix-2 shift-add over a 2·WIDTH product. {HI,LO} ← product.
- MADD/MSUB: {HI,LO} ← {HI,LO} ± signed product, modulo 2^(2·WIDTH).
- Divide: restoring algorithm. LO ← quotient, HI ← remainder.
- Division by zero is defined, not trapped: LO ← all ones, HI ← a. This applies to both signed and unsigned.
- Signed overflow (most-negative / −1): LO ← most-negative, HI ← 0.
- HI/LO are written only in FIX or by MTHI/MTLO. Operands are latched at accept, so a/b may change afterwards.
- stall = busy & (start | mf_req).
  - An op is not accepted while busy.
  - The requester holds start/op/a/b until stall drops.
- kill while busy: next edge →IDLE. HI/LO are unchanged and done does not pulse.
- kill in IDLE suppresses a simultaneous start, including MTHI/MTLO.
- Rst in any state, including mid-RUN: next edge →IDLE. HI, LO, counter, done and all operand registers clear to 0.

## Timing
- Reset values: hi_out=0, lo_out=0, busy=0, done=0. stall=0 follows, since busy=0.
- Multi-cycle op accepted at edge E0 (start high in cycle 0):
  - busy is high from cycle 1 through cycle WIDTH+1.
  - HI/LO commit at edge E(WIDTH+1).
  - done is high in cycle WIDTH+2 and busy is low.
  - Accept-to-result latency is WIDTH+2 cycles (34 at WIDTH=32).
- Back-to-back: a stalled start is accepted at the first edge where busy=0, which is the edge ending the done cycle. No extra bubble.
- mf_req during busy: stall is high through cycle WIDTH+1. In the done cycle, hi_out/lo_out already show the new values.
- MTHI/MTLO: latency 1; the new value is visible in the next cycle.
- stall is combinational from busy, start and mf_req. busy and done are registered.

## Structure
- Package hilo_pkg holds: the op-code localparams; the state enum (IDLE, RUN, FIX); and a function is_signed(op).
- Sub-module muldiv_iter holds the datapath: magnitude registers, the 2·WIDTH accumulator/remainder, the WIDTH-step counter and the shift-add / restore-subtract step.
  - Controls: load, step, mode (mul/div).
  - muldiv_iter has no knowledge of HI/LO.
- The top level holds: the FSM, sign fix-up, MADD/MSUB accumulate, div-by-zero/overflow overrides, the HI/LO registers and stall/done logic.

## Test plan
- MULT, a=−3, b=5 at WIDTH=32 → done in cycle 34; HI=FFFFFFFF, LO=FFFFFFF1. Repeat as MULTU, a=FFFFFFFD, b=5 → HI=4, LO=FFFFFFF1.
- DIV, a=−7, b=2 → LO=FFFFFFFD, HI=FFFFFFFF. DIVU, a=7, b=0 → LO=FFFFFFFF, HI=7. DIV, a=80000000, b=FFFFFFFF → LO=80000000, HI=0.
- Accumulate: MTHI 0, then MTLO FFFFFFFF (each visible next cycle), then MADD a=1, b=1 → HI=1, LO=0. Then MSUB a=1, b=1 → HI=0, LO=FFFFFFFF.
- Stall: MULT accepted, then hold mf_req=1 → stall high cycles 1–33 and low in cycle 34, where lo_out already shows the result. A second start held during busy is accepted at the end of cycle 34.
- Abort: kill in cycle 10 of a DIV → busy low from cycle 11, HI/LO unchanged, no done pulse. Kill+start together in IDLE → no state change.
- Reset mid-RUN (cycle 15), plus the WIDTH=8 configuration: all outputs 0 next cycle. At WIDTH=8, MULT 0x7F·0x7F → HI=0x3F, LO=0x01, done in cycle 10.

Source files
------------

// File: rtl/hilo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hilo_pkg : op codes, FSM states and helpers for hilo_muldiv_unit     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_iter : radix-2 shift-add multiply / restoring divide core     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module muldiv_iter
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               mode_div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic               last,
  output logic [2*WIDTH-1:0] acc
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    sub_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    if (load) begin
      div_d  = mode_div;
      cnt_d  = '0;
      opnd_d = mode_div ? b_mag : a_mag;
      acc_d  = {{WIDTH{1'b0}}, (mode_div ? a_mag : b_mag)};
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        acc_d = sub_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                : {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {add_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  assign last = step && (cnt_q == CW'(WIDTH - 1));
  assign acc  = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else begin
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hilo_muldiv_unit : iterative MULT/DIV/MADD/MSUB unit owning HI/LO    |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  input  logic             mf_req,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               accept, mt_write, in_sgn, res_neg, rem_neg, iter_last;
  logic [WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] iter_acc, prod_fix, hilo_new;

  always_comb begin
    accept   = (state_q == S_IDLE) && start && !kill && (op <= OP_MSUB);
    mt_write = (state_q == S_IDLE) && start && !kill && (op >= OP_MTHI);
    in_sgn   = is_signed(op);
    a_mag    = (in_sgn && a[WIDTH-1]) ? -a : a;
    b_mag    = (in_sgn && b[WIDTH-1]) ? -b : b;
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (Clk),
    .rst      (Rst),
    .load     (accept),
    .step     (state_q == S_RUN),
    .mode_div (is_div(op)),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .last     (iter_last),
    .acc      (iter_acc)
  );

  // Sign fix-up and architectural overrides, consumed in FIX
  always_comb begin
    res_neg  = is_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    rem_neg  = is_signed(op_q) && a_q[WIDTH-1];
    prod_fix = res_neg ? -iter_acc : iter_acc;
    quot_fix = res_neg ? -iter_acc[WIDTH-1:0] : iter_acc[WIDTH-1:0];
    rem_fix  = rem_neg ? -iter_acc[2*WIDTH-1:WIDTH] : iter_acc[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MADD: hilo_new = {hi_q, lo_q} + prod_fix;
      OP_MSUB: hilo_new = {hi_q, lo_q} - prod_fix;
      OP_DIV, OP_DIVU: begin
        if (b_q == '0)
          hilo_new = {a_q, {WIDTH{1'b1}}};
        else if ((op_q == OP_DIV) && (a_q == MOST_NEG) && (b_q == '1))
          hilo_new = {{WIDTH{1'b0}}, MOST_NEG};
        else
          hilo_new = {rem_fix, quot_fix};
      end
      default: hilo_new = prod_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = accept ? a  : a_q;
    b_d     = accept ? b  : b_q;
    op_d    = accept ? op : op_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_RUN;
        if (mt_write && (op == OP_MTHI)) hi_d = a;
        if (mt_write && (op == OP_MTLO)) lo_d = a;
      end
      S_RUN: begin
        if (kill)           state_d = S_IDLE;
        else if (iter_last) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!kill) begin
          {hi_d, lo_d} = hilo_new;
          done_d       = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stall  = busy_q && (start || mf_req);
  assign busy   = busy_q;
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hilo_muldiv_unit : directed bench with arithmetic reference model |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, kill, mf_req;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        stall, busy, done;
  logic [31:0] hi_out, lo_out;

  logic        rst8, start8, kill8, mf8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        stall8, busy8, done8;
  logic [7:0]  hi8, lo8;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(clk), .Rst(rst), .start(start), .op(op), .a(a), .b(b), .kill(kill),
    .mf_req(mf_req), .stall(stall), .busy(busy), .done(done),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  hilo_muldiv_unit #(.WIDTH(8)) dut8 (
    .Clk(clk), .Rst(rst8), .start(start8), .op(op8), .a(a8), .b(b8), .kill(kill8),
    .mf_req(mf8), .stall(stall8), .busy(busy8), .done(done8),
    .hi_out(hi8), .lo_out(lo8)
  );

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural result of one HI/LO operation, from plain integer arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] acc);
    longint sx, sy;
    logic [63:0] sprod, uprod;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    sprod = 64'(sx * sy);
    uprod = {32'b0, x} * {32'b0, y};
    case (o)
      OP_MULT:  return sprod;
      OP_MULTU: return uprod;
      OP_MADD:  return acc + sprod;
      OP_MSUB:  return acc - sprod;
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      OP_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: return acc;
    endcase
  endfunction

  // Cycle model: an accepted op keeps the unit busy for WIDTH+1 cycles, then commits
  int          m_left = 0;
  logic [63:0] m_hilo = '0;
  logic [63:0] m_pend = '0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_hilo = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (kill) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hilo = m_pend;
            m_done = 1'b1;
          end
        end
      end else if (start && !kill) begin
        if (op == OP_MTHI)      m_hilo[63:32] = a;
        else if (op == OP_MTLO) m_hilo[31:0]  = a;
        else begin
          m_pend = ref_result(op, a, b, m_hilo);
          m_left = 33;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_hi",    64'(hi_out), 64'(m_hilo[63:32]));
      chk("cyc_lo",    64'(lo_out), 64'(m_hilo[31:0]));
      chk("cyc_busy",  64'(busy),   64'(m_left > 0));
      chk("cyc_done",  64'(done),   64'(m_done));
      chk("cyc_stall", 64'(stall),  64'((m_left > 0) && (start || mf_req)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo, input string name);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    wait_done(n);
    chk({name, "_latency"}, 64'(n), 64'd34);
    chk({name, "_hi"}, 64'(hi_out), 64'(ehi));
    chk({name, "_lo"}, 64'(lo_out), 64'(elo));
  endtask

  task automatic move_to(input logic [2:0] o, input logic [31:0] x);
    start = 1'b1; op = o; a = x;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; kill = 1'b0; mf_req = 1'b0; op = '0; a = '0; b = '0;
    rst8 = 1'b1; start8 = 1'b0; kill8 = 1'b0; mf8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst8_all", {hi8, lo8, 5'd0, busy8, done8, stall8}, 24'd0);
    rst = 1'b0; rst8 = 1'b0;

    chk("model_mult", ref_result(OP_MULT, 32'hFFFFFFFD, 32'd5, 64'd0), 64'hFFFFFFFF_FFFFFFF1);
    chk("model_div",  ref_result(OP_DIV, 32'hFFFFFFF9, 32'd2, 64'd0), 64'hFFFFFFFF_FFFFFFFD);

    run_op(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, "mult");
    run_op(OP_MULTU, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, "multu");
    run_op(OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, "mult_big");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    run_op(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_negb");
    run_op(OP_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, "divu_zero");
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");

    move_to(OP_MTHI, 32'h12345678);
    chk("mthi_val", 64'(hi_out), 64'h12345678);
    chk("mthi_nodone", {busy, done}, 2'b00);
    move_to(OP_MTHI, 32'h0);
    chk("mthi0", 64'(hi_out), 64'd0);
    move_to(OP_MTLO, 32'hFFFFFFFF);
    chk("mtlo", 64'(lo_out), 64'hFFFFFFFF);
    run_op(OP_MADD, 32'd1, 32'd1, 32'h00000001, 32'h00000000, "madd");
    run_op(OP_MSUB, 32'd1, 32'd1, 32'h00000000, 32'hFFFFFFFF, "msub");

    // mf_req and a second start both held while busy
    start = 1'b1; op = OP_MULT; a = 32'hFFFFFFFD; b = 32'd5;
    tick();
    op = OP_DIVU; a = 32'd100; b = 32'd7; mf_req = 1'b1;
    n = 0;
    for (int k = 1; k <= 33; k++) begin
      if (stall) n++;
      tick();
    end
    chk("stall_cycles", 64'(n), 64'd33);
    chk("stall_c34", 64'(stall), 64'd0);
    chk("done_c34", 64'(done), 64'd1);
    chk("lo_c34", 64'(lo_out), 64'hFFFFFFF1);
    tick();
    chk("b2b_busy", 64'(busy), 64'd1);
    start = 1'b0; mf_req = 1'b0;
    wait_done(n);
    chk("b2b_latency", 64'(n), 64'd34);
    chk("b2b_hilo", {hi_out, lo_out}, {32'd2, 32'd14});

    // kill in cycle 10 of a DIV
    start = 1'b1; op = OP_DIV; a = 32'hFFFFFFF9; b = 32'd2;
    tick();
    start = 1'b0;
    repeat (9) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_busy", 64'(busy), 64'd0);
    chk("kill_hilo", {hi_out, lo_out}, {32'd2, 32'd14});
    n = 0;
    repeat (40) begin
      if (done) n++;
      tick();
    end
    chk("kill_nodone", 64'(n), 64'd0);

    // kill together with start in IDLE
    start = 1'b1; kill = 1'b1; op = OP_MTHI; a = 32'hDEADBEEF;
    tick();
    chk("killmt_hi", 64'(hi_out), 64'd2);
    op = OP_MULT;
    tick();
    start = 1'b0; kill = 1'b0;
    tick();
    chk("killst_busy", 64'(busy), 64'd0);

    // reset in cycle 15 of a MULT
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
    tick();
    start = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrun_all", {hi_out, lo_out, busy, done}, 66'd0);
    repeat (40) tick();

    // WIDTH=8 instance
    start8 = 1'b1; op8 = OP_MULT; a8 = 8'h7F; b8 = 8'h7F;
    tick();
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 100) begin tick(); n++; end
    chk("w8_mult_latency", 64'(n), 64'd10);
    chk("w8_mult_hilo", {hi8, lo8}, 16'h3F01);
    start8 = 1'b1; op8 = OP_DIV; a8 = 8'hF9; b8 = 8'h02;
    tick();
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 100) begin tick(); n++; end
    chk("w8_div_latency", 64'(n), 64'd10);
    chk("w8_div_hilo", {hi8, lo8}, 16'hFFFD);
    start8 = 1'b1; op8 = OP_MULTU; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    chk("w8_rstrun_all", {hi8, lo8, busy8, done8}, 18'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
